// File: rtl/MIPS_pkg.sv
// MIPS_pkg: shared opcode, funct, select and state encodings for the
// multi-cycle MIPS controller.
`default_nettype none

package MIPS_pkg;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_BEQ   = 6'h04,
    OP_ADDI  = 6'h08,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } mips_op_e;

  typedef enum logic [5:0] {
    FUNCT_ADD  = 6'h20,
    FUNCT_ADDU = 6'h21,
    FUNCT_SUB  = 6'h22,
    FUNCT_SUBU = 6'h23,
    FUNCT_AND  = 6'h24,
    FUNCT_OR   = 6'h25,
    FUNCT_SLT  = 6'h2A
  } mips_funct_e;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd6,
    ALU_SLT = 3'd7
  } mips_alu_ctrl_e;

  typedef enum logic [1:0] {
    SRCB_REGB   = 2'd0,
    SRCB_FOUR   = 2'd1,
    SRCB_IMM    = 2'd2,
    SRCB_IMM_SH = 2'd3
  } mips_alusrcb_e;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'd0,
    PCSRC_ALUOUT = 2'd1,
    PCSRC_JUMP   = 2'd2
  } mips_pcsrc_e;

  typedef enum logic [3:0] {
    S_FETCH         = 4'd0,
    S_DECODE        = 4'd1,
    S_MEMADDR       = 4'd2,
    S_MEMREAD       = 4'd3,
    S_MEMWRITEBACK  = 4'd4,
    S_MEMWRITE      = 4'd5,
    S_EXECUTE       = 4'd6,
    S_ALUWRITEBACK  = 4'd7,
    S_BRANCH        = 4'd8,
    S_ADDIEXECUTE   = 4'd9,
    S_ADDIWRITEBACK = 4'd10,
    S_JUMP          = 4'd11
  } mips_state_e;

endpackage

`default_nettype wire

// File: rtl/mips_alu_decoder.sv
// mips_alu_decoder: maps an R-type funct field to an ALU operation and
// flags whether the funct is one the core implements.
`default_nettype none

module mips_alu_decoder
  import MIPS_pkg::*;
(
  input  mips_funct_e    funct,
  output mips_alu_ctrl_e alu_ctrl,
  output logic           funct_valid
);

  always_comb begin
    alu_ctrl    = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FUNCT_ADD, FUNCT_ADDU: alu_ctrl = ALU_ADD;
      FUNCT_SUB, FUNCT_SUBU: alu_ctrl = ALU_SUB;
      FUNCT_AND:             alu_ctrl = ALU_AND;
      FUNCT_OR:              alu_ctrl = ALU_OR;
      FUNCT_SLT:             alu_ctrl = ALU_SLT;
      default:               funct_valid = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mips_control_unit.sv
// mips_control_unit: multi-cycle main controller; sequences each instruction
// through fetch/decode/execute states and drives all datapath controls.
`default_nettype none

module mips_control_unit
  import MIPS_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  mips_op_e       op,
  input  mips_funct_e    funct,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           mem_read,
  output logic           mem_write,
  output logic           iord,
  output logic           ir_write,
  output logic           pc_en,
  output mips_pcsrc_e    pc_src,
  output logic           alu_src_a,
  output mips_alusrcb_e  alu_src_b,
  output mips_alu_ctrl_e alu_ctrl,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           reg_write,
  output logic           illegal_instr,
  output mips_state_e    state
);

  mips_state_e    next_state;
  mips_alu_ctrl_e dec_ctrl;
  logic           funct_valid;

  mips_alu_decoder u_alu_dec (
    .funct       (funct),
    .alu_ctrl    (dec_ctrl),
    .funct_valid (funct_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= next_state;
  end

  always_comb begin
    next_state    = S_FETCH;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_en         = 1'b0;
    pc_src        = PCSRC_ALU;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REGB;
    alu_ctrl      = ALU_ADD;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write   = 1'b1;
          pc_en      = 1'b1;
          next_state = S_DECODE;
        end else begin
          next_state = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADDR;
          OP_BEQ:       next_state = S_BRANCH;
          OP_ADDI:      next_state = S_ADDIEXECUTE;
          OP_J:         next_state = S_JUMP;
          OP_RTYPE: begin
            if (funct_valid) next_state = S_EXECUTE;
            else             illegal_instr = 1'b1;
          end
          default:      illegal_instr = 1'b1;
        endcase
      end
      S_MEMADDR: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        iord       = 1'b1;
        mem_read   = 1'b1;
        next_state = mem_ready ? S_MEMWRITEBACK : S_MEMREAD;
      end
      S_MEMWRITEBACK: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        next_state = mem_ready ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTE: begin
        alu_src_a  = 1'b1;
        alu_ctrl   = dec_ctrl;
        next_state = S_ALUWRITEBACK;
      end
      S_ALUWRITEBACK: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_ctrl  = ALU_SUB;
        pc_src    = PCSRC_ALUOUT;
        pc_en     = zero;
      end
      S_ADDIEXECUTE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        next_state = S_ADDIWRITEBACK;
      end
      S_ADDIWRITEBACK: reg_write = 1'b1;
      S_JUMP: begin
        pc_src = PCSRC_JUMP;
        pc_en  = 1'b1;
      end
      default: next_state = S_FETCH;
    endcase

    // Reset overrides everything so no enable or select leaks out mid-instruction.
    if (!rst_n) begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_en         = 1'b0;
      pc_src        = PCSRC_ALU;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REGB;
      alu_ctrl      = ALU_ADD;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: doc/mips_control_unit.md
# mips_control_unit

- Multi-cycle main controller for the non-pipelined MIPS core.
- Consumes the decoded `op`/`funct` fields of the instruction register and the ALU `zero` flag; sequences instructions through the `mips_state_e` state machine.
- Drives every datapath mux select, register/memory write enable and the ALU control code.
- Inserts memory wait states via a `mem_ready` handshake.

## Interface
Parameters: none (all widths from `MIPS_pkg`).
- clk  in  1  core clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- op  in  mips_op_e  opcode from instruction register
- funct  in  mips_funct_e  function field from instruction register
- zero  in  1  ALU result == 0
- mem_ready  in  1  memory completes current access this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- iord  out  1  address mux: 0 = PC, 1 = ALUOut
- ir_write  out  1  instruction register load
- pc_en  out  1  PC load (already includes branch qualification)
- pc_src  out  mips_pcsrc_e  0 = ALU result, 1 = ALUOut, 2 = jump target
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  mips_alusrcb_e  0 = reg B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
- alu_ctrl  out  mips_alu_ctrl_e  ALU operation
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = data register
- reg_write  out  1  register file write
- illegal_instr  out  1  one-cycle pulse on unsupported op/funct
- state  out  mips_state_e  current state, debug/verification only

## Operation
- Default output values: all 1-bit outputs 0, `pc_src` = 0, `alu_src_b` = 0, `alu_ctrl` = ADD. Each state overrides only the outputs listed for it.
- FETCH:
  - Outputs: `mem_read`=1, `alu_src_b`=1.
  - If `mem_ready`: `ir_write`=1, `pc_en`=1, go to DECODE; else stay.
- DECODE:
  - Outputs: `alu_src_b`=3.
  - LW/SW go to MEMADDR; RTYPE to EXECUTE; BEQ to BRANCH; ADDI to ADDIEXECUTE; J to JUMP.
  - RTYPE with funct outside {ADD, ADDU, SUB, SUBU, AND, OR, SLT}, or any other op: `illegal_instr`=1, go to FETCH. The instruction acts as a NOP; the PC is already advanced.
- MEMADDR:
  - Outputs: `alu_src_a`=1, `alu_src_b`=2.
  - LW goes to MEMREAD; SW to MEMWRITE.
- MEMREAD: `iord`=1, `mem_read`=1. Stay until `mem_ready`, then go to MEMWRITEBACK.
- MEMWRITEBACK: `mem_to_reg`=1, `reg_write`=1; go to FETCH.
- MEMWRITE: `iord`=1, `mem_write`=1. Held high until `mem_ready`, then go to FETCH.
- EXECUTE:
  - Outputs: `alu_src_a`=1, `alu_ctrl` from funct. ADDU maps to ADD, SUBU to SUB.
  - Go to ALUWRITEBACK.
- ALUWRITEBACK: `reg_dst`=1, `reg_write`=1; go to FETCH.
- BRANCH:
  - Outputs: `alu_src_a`=1, `alu_ctrl`=SUB, `pc_src`=1, `pc_en` = `zero`.
  - Go to FETCH.
- ADDIEXECUTE: `alu_src_a`=1, `alu_src_b`=2; go to ADDIWRITEBACK.
- ADDIWRITEBACK: `reg_write`=1; go to FETCH.
- JUMP: `pc_src`=2, `pc_en`=1; go to FETCH.
- State-encoding values outside the enum go to FETCH, with all outputs at defaults.

## Timing
- State register updates on the `clk` rising edge.
- Outputs are combinational from `state`. The only input dependencies are:
  - `mem_ready` (FETCH)
  - `zero` (BRANCH)
  - `funct` (EXECUTE)
  - `op`/`funct` (DECODE: `illegal_instr`)
- Reset:
  - `rst_n`=0 at an edge forces `state`=FETCH, including mid-instruction; any partial instruction is abandoned.
  - While `rst_n`=0, all enables (`mem_read`, `mem_write`, `ir_write`, `pc_en`, `reg_write`, `illegal_instr`) are forced 0.
  - All selects take default values during reset.
- Latency with `mem_ready` held 1: LW 5 cycles; SW, RTYPE and ADDI 4; BEQ and J 3; illegal 2.
- Each cycle with `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Request signals (`mem_read`/`mem_write`) and the address select stay stable throughout a stall.
- `op`/`funct` must be stable from DECODE through the end of the instruction; the instruction register is loaded only in FETCH.

## Structure
- Add to `MIPS_pkg`:
  - `mips_alu_ctrl_e` (3 bits: AND=0, OR=1, ADD=2, SUB=6, SLT=7)
  - `mips_alusrcb_e` (2 bits)
  - `mips_pcsrc_e` (2 bits)
- Sub-module `mips_alu_decoder`: combinational funct → `mips_alu_ctrl_e` plus a `funct_valid` output. DECODE uses `funct_valid` for illegal detection.

## Test plan
- LW, `mem_ready`=1: states FETCH, DECODE, MEMADDR, MEMREAD, MEMWRITEBACK, FETCH. `reg_write`=1 with `mem_to_reg`=1 exactly in cycle 5.
- SW, `mem_ready` low for 2 cycles in MEMWRITE: `mem_write`=1 and `iord`=1 for 3 consecutive cycles, then FETCH. `reg_write` never asserted.
- BEQ:
  - `zero`=1: `pc_en`=1 with `pc_src`=1 in BRANCH.
  - `zero`=0: `pc_en`=0. Both cases return to FETCH after 3 cycles.
- RTYPE SUB (funct 0x22): `alu_ctrl`=6 in EXECUTE; `reg_dst`=1 and `reg_write`=1 next cycle.
- Illegal cases: op 0x3F, and RTYPE with funct 0x27 (NOR) → `illegal_instr` pulses 1 cycle in DECODE, next state FETCH, no write enables asserted.
- Reset mid-instruction: `rst_n`=0 in MEMREAD → next `state`=FETCH, enables 0 during reset. After release, FETCH asserts `mem_read`=1 and `iord`=0.
